// File: rtl/axonerve_wordcount_axi_mem_responder_if.sv
// AXI4 subset bundle used by the wordcount kernel's m00_axi port.
// The master drives requests and write data; the slave answers.
interface axonerve_wordcount_axi_mem_responder_if #(
  parameter int C_ADDR_WIDTH = 64,
  parameter int C_DATA_WIDTH = 512
);
  logic                      awvalid;
  logic                      awready;
  logic [C_ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]                awlen;
  logic                      wvalid;
  logic                      wready;
  logic [C_DATA_WIDTH-1:0]   wdata;
  logic [C_DATA_WIDTH/8-1:0] wstrb;
  logic                      wlast;
  logic                      bvalid;
  logic                      bready;
  logic                      arvalid;
  logic                      arready;
  logic [C_ADDR_WIDTH-1:0]   araddr;
  logic [7:0]                arlen;
  logic                      rvalid;
  logic                      rready;
  logic [C_DATA_WIDTH-1:0]   rdata;
  logic                      rlast;

  modport master (
    output awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arlen, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata, rlast
  );

  modport slave (
    input  awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arlen, rready,
    output awready, wready, bvalid, arready, rvalid, rdata, rlast
  );
endinterface

// File: rtl/axonerve_wordcount_axi_mem_responder.sv
// BRAM-backed AXI4 memory responder: INCR write bursts with byte strobes,
// INCR read bursts at one beat per two cycles, plus sticky burst status.
module axonerve_wordcount_axi_mem_responder #(
  parameter int C_ADDR_WIDTH     = 64,
  parameter int C_DATA_WIDTH     = 512,
  parameter int C_MEM_DEPTH_LOG2 = 10
) (
  input  logic        ap_clk,
  input  logic        areset,
  axonerve_wordcount_axi_mem_responder_if.slave s_axi,
  output logic        wlast_error,
  output logic [31:0] wr_burst_count,
  output logic [31:0] rd_burst_count
);
  localparam int STRB_W = C_DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = C_MEM_DEPTH_LOG2;
  localparam int DEPTH  = 1 << IDX_W;

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  logic [C_DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic     ready_en;
  idx_t     wr_idx, rd_idx;
  logic [7:0] wr_len, wr_cnt, rd_len, rd_cnt;
  logic [C_DATA_WIDTH-1:0] rdata_q;

  logic aw_hs, w_hs, w_final, b_hs, ar_hs, r_hs, r_final, wlast_bad;

  assign aw_hs     = s_axi.awvalid && s_axi.awready;
  assign w_hs      = s_axi.wvalid && s_axi.wready;
  assign b_hs      = s_axi.bvalid && s_axi.bready;
  assign ar_hs     = s_axi.arvalid && s_axi.arready;
  assign r_hs      = s_axi.rvalid && s_axi.rready;
  assign w_final   = (wr_cnt == wr_len);
  assign r_final   = (rd_cnt == rd_len);
  assign wlast_bad = w_hs && (s_axi.wlast != w_final);

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next        = w_state;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        s_axi.awready = ready_en;
        if (s_axi.awvalid && ready_en) w_next = W_DATA;
      end
      W_DATA: begin
        s_axi.wready = 1'b1;
        if (s_axi.wvalid && w_final) w_next = W_RESP;
      end
      W_RESP: begin
        s_axi.bvalid = 1'b1;
        if (s_axi.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next        = r_state;
    s_axi.arready = 1'b0;
    s_axi.rvalid  = 1'b0;
    s_axi.rlast   = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        s_axi.arready = ready_en;
        if (s_axi.arvalid && ready_en) r_next = R_FETCH;
      end
      R_FETCH: r_next = R_DATA;
      R_DATA: begin
        s_axi.rvalid = 1'b1;
        s_axi.rlast  = r_final;
        if (s_axi.rready) r_next = r_final ? R_IDLE : R_FETCH;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign s_axi.rdata = rdata_q;

  // ready_en holds both address channels off for one cycle after reset.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      w_state        <= W_IDLE;
      r_state        <= R_IDLE;
      ready_en       <= 1'b0;
      wr_idx         <= '0;
      wr_len         <= '0;
      wr_cnt         <= '0;
      rd_idx         <= '0;
      rd_len         <= '0;
      rd_cnt         <= '0;
      rdata_q        <= '0;
      wlast_error    <= 1'b0;
      wr_burst_count <= '0;
      rd_burst_count <= '0;
    end else begin
      w_state  <= w_next;
      r_state  <= r_next;
      ready_en <= 1'b1;

      if (aw_hs) begin
        wr_idx <= s_axi.awaddr[OFF_W +: IDX_W];
        wr_len <= s_axi.awlen;
        wr_cnt <= '0;
      end else if (w_hs) begin
        wr_idx <= wr_idx + 1'b1;
        wr_cnt <= wr_cnt + 8'd1;
      end
      if (wlast_bad) wlast_error <= 1'b1;
      if (b_hs) wr_burst_count <= wr_burst_count + 32'd1;

      if (ar_hs) begin
        rd_idx <= s_axi.araddr[OFF_W +: IDX_W];
        rd_len <= s_axi.arlen;
        rd_cnt <= '0;
      end else if (r_hs) begin
        rd_idx <= rd_idx + 1'b1;
        rd_cnt <= rd_cnt + 8'd1;
      end
      if (r_state == R_FETCH) rdata_q <= mem[rd_idx];
      if (r_hs && r_final) rd_burst_count <= rd_burst_count + 32'd1;
    end
  end

  // NOTE: the array has no reset so it maps onto block RAM; contents survive areset.
  // Non-blocking write keeps a same-cycle read of this index returning old data.
  always_ff @(posedge ap_clk) begin
    if (!areset && w_hs) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.wstrb[b]) mem[wr_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axonerve_wordcount_axi_mem_responder.sv
// Scoreboard bench: tasks push expected read beats / B results into queues,
// a negedge monitor compares whatever the responder presents.
module tb_axonerve_wordcount_axi_mem_responder;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int SW = DW / 8;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } rbeat_t;

  logic        ap_clk = 1'b0;
  logic        areset = 1'b1;
  logic        wlast_error;
  logic [31:0] wr_burst_count, rd_burst_count;

  axonerve_wordcount_axi_mem_responder_if #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) bus ();

  axonerve_wordcount_axi_mem_responder #(
    .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_MEM_DEPTH_LOG2(10)
  ) dut (
    .ap_clk(ap_clk),
    .areset(areset),
    .s_axi(bus.slave),
    .wlast_error(wlast_error),
    .wr_burst_count(wr_burst_count),
    .rd_burst_count(rd_burst_count)
  );

  always #5 ap_clk = ~ap_clk;

  int            tests = 0;
  int            fails = 0;
  int            beats_seen = 0;
  int            exp_wr = 0;
  int            exp_rd = 0;
  logic          exp_err = 1'b0;
  logic [DW-1:0] model [DEPTH];
  rbeat_t        r_q [$];
  logic          b_q [$];
  logic          b_exp;

  function automatic logic [DW-1:0] pat(input logic [31:0] s);
    return {16{s}};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: handshake wait expired", name);
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  // Monitor: compare every presented read beat against the queue head.
  always @(negedge ap_clk) begin
    if (!areset && bus.rvalid) begin
      tests++;
      if (r_q.size() == 0) begin
        fails++;
        $display("FAIL r_unexpected: rvalid=1 with no beat expected");
      end else begin
        if (bus.rdata !== r_q[0].data || bus.rlast !== r_q[0].last) begin
          fails++;
          $display("FAIL rbeat: rdata[63:0]=%h rlast=%b, expected rdata[63:0]=%h rlast=%b",
                   bus.rdata[63:0], bus.rlast, r_q[0].data[63:0], r_q[0].last);
        end
        if (bus.rready) begin
          void'(r_q.pop_front());
          beats_seen++;
        end
      end
    end
    if (!areset && bus.bvalid && bus.bready) begin
      tests++;
      if (b_q.size() == 0) begin
        fails++;
        $display("FAIL b_unexpected: bvalid=1 with no burst outstanding");
      end else begin
        b_exp = b_q.pop_front();
        if (wlast_error !== b_exp) begin
          fails++;
          $display("FAIL b_wlast_error: got %b, expected %b", wlast_error, b_exp);
        end
      end
    end
  end

  // bad_last < 0 means wlast on the true final beat; otherwise wlast only on that beat.
  task automatic do_write(input logic [AW-1:0] addr, input int len, input logic [31:0] seed,
                          input logic [SW-1:0] strb, input int bad_last, input bit timing);
    int idx;
    int n;
    logic [DW-1:0] d;
    idx = int'(addr[15:6]);
    exp_err = exp_err | ((bad_last >= 0) && (bad_last != len));
    b_q.push_back(exp_err);
    bus.awaddr  = addr;
    bus.awlen   = 8'(len);
    bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin step(); n++; end
    if (n == 50) begin timeout("aw_wait"); bus.awvalid = 1'b0; return; end
    step();
    bus.awvalid = 1'b0;
    if (timing) check("wready_after_aw", 64'(bus.wready), 64'd1);
    for (int k = 0; k <= len; k++) begin
      d = pat(seed + 32'(k));
      bus.wdata  = d;
      bus.wstrb  = strb;
      bus.wlast  = (bad_last >= 0) ? (k == bad_last) : (k == len);
      bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < 50) begin step(); n++; end
      if (n == 50) begin timeout("w_wait"); bus.wvalid = 1'b0; return; end
      step();
      for (int b = 0; b < SW; b++) if (strb[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
      idx = (idx + 1) % DEPTH;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    if (timing) begin
      check("bvalid_after_last_w", 64'(bus.bvalid), 64'd1);
      check("wready_after_last_w", 64'(bus.wready), 64'd0);
    end
    n = 0;
    while (bus.bvalid && n < 50) begin step(); n++; end
    if (n == 50) begin timeout("b_wait"); return; end
    if (timing) check("awready_after_b", 64'(bus.awready), 64'd1);
    exp_wr++;
    check("wr_burst_count", 64'(wr_burst_count), 64'(exp_wr));
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int len, input bit toggle);
    int idx;
    int n;
    int target;
    rbeat_t e;
    idx = int'(addr[15:6]);
    for (int k = 0; k <= len; k++) begin
      e.data = model[idx];
      e.last = (k == len);
      r_q.push_back(e);
      idx = (idx + 1) % DEPTH;
    end
    target = beats_seen + len + 1;
    bus.araddr  = addr;
    bus.arlen   = 8'(len);
    bus.arvalid = 1'b1;
    bus.rready  = !toggle;
    n = 0;
    while (!bus.arready && n < 50) begin step(); n++; end
    if (n == 50) begin timeout("ar_wait"); bus.arvalid = 1'b0; return; end
    step();
    bus.arvalid = 1'b0;
    n = 0;
    while (beats_seen < target && n < 400) begin
      step();
      if (toggle) bus.rready = !bus.rready;
      n++;
    end
    bus.rready = 1'b0;
    if (beats_seen < target) begin timeout("r_beats"); return; end
    exp_rd++;
    check("rd_burst_count", 64'(rd_burst_count), 64'(exp_rd));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.awvalid = 0; bus.awaddr = '0; bus.awlen = '0;
    bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0;
    bus.bready = 1'b1;
    bus.arvalid = 0; bus.araddr = '0; bus.arlen = '0; bus.rready = 0;

    // Reset state and release timing.
    repeat (3) step();
    check("rst_awready", 64'(bus.awready), 64'd0);
    check("rst_arready", 64'(bus.arready), 64'd0);
    check("rst_bvalid", 64'(bus.bvalid), 64'd0);
    check("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check("rst_wlast_error", 64'(wlast_error), 64'd0);
    check("rst_wr_count", 64'(wr_burst_count), 64'd0);
    check("rst_rd_count", 64'(rd_burst_count), 64'd0);
    areset = 1'b0;
    step();
    check("awready_after_release", 64'(bus.awready), 64'd1);
    check("arready_after_release", 64'(bus.arready), 64'd1);

    // Basic 4-beat write then read back.
    do_write(64'h0, 3, 32'h0000_0100, {SW{1'b1}}, -1, 1'b1);
    do_read(64'h0, 3, 1'b0);

    // Byte-strobe merge: only bytes 0-3 replaced over all-ones.
    do_write(64'h40, 0, 32'hFFFF_FFFF, {SW{1'b1}}, -1, 1'b0);
    do_write(64'h40, 0, 32'h1234_5678, 64'hF, -1, 1'b0);
    do_read(64'h40, 0, 1'b0);

    // Index wrap at the top of memory; high address bits and byte offset ignored.
    do_write(64'hFFC0, 1, 32'h0000_2000, {SW{1'b1}}, -1, 1'b0);
    do_read(64'hABCD_0000_0000_FFC5, 1, 1'b0);
    do_read(64'h0, 0, 1'b0);

    // Early wlast: error flagged, burst still four beats, one B.
    do_write(64'h200, 3, 32'h0000_4000, {SW{1'b1}}, 1, 1'b0);
    check("wlast_error_sticky", 64'(wlast_error), 64'd1);
    do_read(64'h200, 3, 1'b0);

    // Stalled read concurrent with a write to other indices.
    fork
      do_read(64'h0, 3, 1'b1);
      do_write(64'h1000, 3, 32'h0000_3000, {SW{1'b1}}, -1, 1'b0);
    join
    do_read(64'h1000, 3, 1'b0);

    // Reset while a read beat is presented.
    begin
      int n;
      rbeat_t e;
      e.data = model[0];
      e.last = 1'b1;
      r_q.push_back(e);
      bus.araddr = 64'h0; bus.arlen = 8'd0; bus.arvalid = 1'b1; bus.rready = 1'b0;
      n = 0;
      while (!bus.arready && n < 50) begin step(); n++; end
      if (n == 50) timeout("ar_wait_rst");
      step();
      bus.arvalid = 1'b0;
      check("rvalid_ar_plus1", 64'(bus.rvalid), 64'd0);
      step();
      check("rvalid_ar_plus2", 64'(bus.rvalid), 64'd1);
      step();
      areset = 1'b1;
      step();
      check("rst_mid_rvalid", 64'(bus.rvalid), 64'd0);
      check("rst_mid_arready", 64'(bus.arready), 64'd0);
      check("rst_mid_wr_count", 64'(wr_burst_count), 64'd0);
      check("rst_mid_rd_count", 64'(rd_burst_count), 64'd0);
      check("rst_mid_wlast_error", 64'(wlast_error), 64'd0);
      r_q.delete();
      b_q.delete();
      exp_wr = 0;
      exp_rd = 0;
      exp_err = 1'b0;
      areset = 1'b0;
      step();
      check("rst_mid_arready_back", 64'(bus.arready), 64'd1);
    end

    // Memory contents survive reset.
    do_read(64'h0, 3, 1'b0);

    repeat (3) step();
    check("scoreboard_drained", 64'(r_q.size() + b_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axonerve_wordcount_axi_mem_responder.md
# axonerve_wordcount_axi_mem_responder

AXI4 memory responder (slave) answering the simplified m00_axi master subset driven by the wordcount kernel's read and write masters. It holds a BRAM-backed word array, accepts INCR write bursts with byte strobes, and returns INCR read bursts. Its main use is as the memory end of kernel-level simulation and on-chip loopback tests. It exposes only the signals the kernel's m00_axi port drives or samples, plus sticky status.

## Interface
- C_ADDR_WIDTH, 64, byte address width of awaddr/araddr
- C_DATA_WIDTH, 512, data beat width; C_DATA_WIDTH/8 strobe bits
- C_MEM_DEPTH_LOG2, 10, log2 of beats stored (default 1024 beats = 64 KiB)

- ap_clk  in  1  single clock
- areset  in  1  synchronous, active-high reset
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_awaddr  in  C_ADDR_WIDTH  burst start byte address
- s_axi_awlen  in  8  beats minus one
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_wdata  in  C_DATA_WIDTH  write beat
- s_axi_wstrb  in  C_DATA_WIDTH/8  byte enables
- s_axi_wlast  in  1  last write beat
- s_axi_bvalid  out  1  write response valid (response always OKAY, not carried)
- s_axi_bready  in  1  write response ready
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_araddr  in  C_ADDR_WIDTH  burst start byte address
- s_axi_arlen  in  8  beats minus one
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- s_axi_rdata  out  C_DATA_WIDTH  read beat
- s_axi_rlast  out  1  last read beat
- wlast_error  out  1  sticky: wlast disagreed with awlen
- wr_burst_count  out  32  completed write bursts (B handshakes)
- rd_burst_count  out  32  completed read bursts (last R handshakes)

## Operation
- Beat index = addr[log2(C_DATA_WIDTH/8) +: C_MEM_DEPTH_LOG2]; low byte-offset bits ignored; higher bits ignored (address wraps modulo depth). Index increments by 1 per beat, wrapping at 2^C_MEM_DEPTH_LOG2 − 1 → 0.
- Write FSM, independent of read FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: awready=1; on awvalid capture index and awlen, clear beat counter.
  - W_DATA: wready=1; each wvalid beat writes bytes where wstrb=1, others unchanged. Burst ends on the beat where counter==awlen. If wlast=1 earlier, or wlast=0 on that final beat, set wlast_error; burst still ends at counter==awlen.
  - W_RESP: bvalid=1 until bready; on handshake increment wr_burst_count.
- Read FSM: R_IDLE → R_FETCH → R_DATA → (R_FETCH | R_IDLE).
  - R_IDLE: arready=1; on arvalid capture index and arlen.
  - R_FETCH: synchronous memory read of current index (one cycle).
  - R_DATA: rvalid=1, rdata registered, rlast=1 when beat counter==arlen. On rready: advance index; go to R_FETCH, or R_IDLE after last beat and increment rd_burst_count.
- Read-during-write to same index in same cycle: read returns old data (read-first).
- Counters wrap at 2^32; wlast_error cleared only by reset.

## Timing
- While areset=1 and the cycle after: all outputs 0, states idle, counters 0, wlast_error 0. Memory contents not reset.
- awready/arready are 1 from the second cycle after areset falls, while idle.
- AW handshake at T → wready=1 from T+1. Final W beat at U → wready=0, bvalid=1 at U+1. B handshake at V → awready=1 at V+1.
- AR handshake at T → rvalid=1 at T+2. R handshake at V (not last) → rvalid=0 at V+1, rvalid=1 at V+2. Peak throughput is 1 read beat per 2 cycles.
- rvalid/rdata/rlast and bvalid are held stable until handshake.
- Only one outstanding burst per direction. Read and write proceed concurrently.
- Reset mid-burst aborts both FSMs. Any partial write beats already committed remain in memory.

## Test plan
- Write awaddr=0x0, awlen=3, 4 beats of pattern k → B after beat 3. Read araddr=0x0, arlen=3 → 4 beats equal pattern, rlast on beat 3 only, wr/rd_burst_count=1.
- Write awaddr=0x40 with wstrb=0x...0F over prior 0xFF.. data, then read → only bytes 0–3 updated.
- awaddr=(2^10−1)*64, awlen=1 → second beat lands at index 0. Read back confirms wrap.
- awlen=3 with wlast asserted on beat 1 → wlast_error=1, burst still takes 4 beats, B issued once.
- Read with rready toggled 1/0 each cycle, concurrent with a write burst to other indices → rdata stable while stalled. Both bursts complete correctly.
- Assert areset during R_DATA → next cycle rvalid=0, arready=0, then arready=1. Counters read 0.
